// File: rtl/ffm_pm_if.sv
`default_nettype none
// ============================================================================
//  Module      : ffm_pm_if
//  Description : Request/response bundle for the pseudo-Mersenne field unit.
//                master drives start/op/a/b and observes busy/result/valid;
//                slave (the arithmetic unit) is the mirror image.
//                  start  : request, only honoured while busy is low
//                  op     : 00 MUL, 01 SQR, 10 ADD, 11 SUB
//                  a, b   : operands, any value in [0, 2^WIDTH-1]
//                  busy   : operation in flight
//                  result : fully reduced result, held until next valid
//                  valid  : one-cycle pulse when result updates
//  Revision    : 1.0 - initial release
// ============================================================================
interface ffm_pm_if #(
  parameter int WIDTH = 255
) ();
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic [WIDTH-1:0] result;
  logic             valid;

  modport master (output start, op, a, b, input busy, result, valid);
  modport slave  (input start, op, a, b, output busy, result, valid);
endinterface
`default_nettype wire

// File: rtl/ffm_pm.sv
`default_nettype none
// ============================================================================
//  Module      : ffm_pm
//  Description : Arithmetic unit modulo P = 2^WIDTH - C. MUL/SQR use a
//                digit-serial multiplier (MSB digit first, DIGIT bits of b
//                per cycle) followed by two folds and one conditional
//                subtract; ADD/SUB enter at the second fold. Latency is
//                fixed: N+3 edges for MUL/SQR (N = ceil(WIDTH/DIGIT)),
//                2 edges for ADD/SUB.
//  Ports       : clk  - rising-edge clock
//                rst  - asynchronous active-low reset
//                bus  - ffm_pm_if slave (start/op/a/b in, busy/result/valid out)
//  Revision    : 1.0 - initial release
// ============================================================================
module ffm_pm #(
  parameter int WIDTH = 255,
  parameter int C     = 19,
  parameter int DIGIT = 16
) (
  input  logic     clk,
  input  logic     rst,
  ffm_pm_if.slave  bus
);

  localparam int N  = (WIDTH + DIGIT - 1) / DIGIT;
  localparam int BW = N * DIGIT;
  localparam int AW = 2 * WIDTH;
  // Two headroom bits beyond the C multiple: FOLD1 output is below
  // (C+1)*2^WIDTH and SUB input is below 3*2^WIDTH.
  localparam int TW = WIDTH + $clog2(C + 1) + 2;
  localparam int CW = $clog2(N + 1);

  localparam logic [TW-1:0] P_T   = (TW'(1) << WIDTH) - TW'(C);
  localparam logic [TW-1:0] TWO_P = P_T << 1;

  localparam logic [1:0] OP_MUL = 2'b00;
  localparam logic [1:0] OP_SQR = 2'b01;
  localparam logic [1:0] OP_ADD = 2'b10;
  localparam logic [1:0] OP_SUB = 2'b11;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_MULT  = 3'd1;
  localparam logic [2:0] S_FOLD1 = 3'd2;
  localparam logic [2:0] S_FOLD2 = 3'd3;
  localparam logic [2:0] S_CORR  = 3'd4;

  logic [2:0]       state_q,  state_d;
  logic [WIDTH-1:0] a_q,      a_d;
  logic [BW-1:0]    b_q,      b_d;
  logic [AW-1:0]    acc_q,    acc_d;
  logic [CW-1:0]    cnt_q,    cnt_d;
  logic [TW-1:0]    t_q,      t_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             valid_q,  valid_d;
  logic             busy;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (bus.op == OP_MUL || bus.op == OP_SQR) state_d = S_MULT;
          else                                      state_d = S_FOLD2;
        end
      end
      S_MULT:  if (cnt_q == CW'(N - 1)) state_d = S_FOLD1;
      S_FOLD1: state_d = S_FOLD2;
      S_FOLD2: state_d = S_CORR;
      S_CORR:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic: busy covers every non-idle state, so it drops on the same
  // edge that raises valid and a new start is accepted in the valid cycle.
  always_comb begin
    busy = (state_q != S_IDLE);
  end

  // Datapath next values
  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    t_d      = t_q;
    result_d = result_q;
    valid_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          a_d   = bus.a;
          acc_d = '0;
          cnt_d = '0;
          case (bus.op)
            OP_SQR:  b_d = BW'(bus.a);
            OP_ADD:  begin
              b_d = BW'(bus.b);
              t_d = TW'(bus.a) + TW'(bus.b);
            end
            OP_SUB:  begin
              b_d = BW'(bus.b);
              // Adding 2P keeps t non-negative for any b below 2^WIDTH.
              t_d = TW'(bus.a) + (TWO_P - TW'(bus.b));
            end
            default: b_d = BW'(bus.b);
          endcase
        end
      end
      S_MULT: begin
        // b is shifted left so its top DIGIT bits are always the next digit.
        acc_d = (acc_q << DIGIT) + AW'(a_q) * AW'(b_q[BW-1 -: DIGIT]);
        b_d   = b_q << DIGIT;
        cnt_d = cnt_q + CW'(1);
      end
      S_FOLD1: begin
        t_d = TW'(acc_q[WIDTH-1:0]) + TW'(acc_q[AW-1:WIDTH]) * TW'(C);
      end
      S_FOLD2: begin
        // 2^WIDTH == C (mod P); after this fold t < 2P.
        t_d = TW'(t_q[WIDTH-1:0]) + TW'(t_q[TW-1:WIDTH]) * TW'(C);
      end
      S_CORR: begin
        result_d = (t_q >= P_T) ? WIDTH'(t_q - P_T) : t_q[WIDTH-1:0];
        valid_d  = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      t_q      <= '0;
      result_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      t_q      <= t_d;
      result_q <= result_d;
      valid_q  <= valid_d;
    end
  end

  assign bus.busy   = busy;
  assign bus.result = result_q;
  assign bus.valid  = valid_q;

endmodule
`default_nettype wire

// File: doc/ffm_pm.md
Name: ffm_pm

Overview:
- Parametrised pseudo-Mersenne field arithmetic unit computing modulo P = 2^WIDTH - C.
- Successor to the fixed 2^255-19 multiplier, used by the scalar-multiplication controller.
- Adds selectable operation (MUL, SQR, ADD, SUB), a self-contained digit-serial multiplier, fixed deterministic latency, and a busy/valid handshake with back-to-back issue.
- Result is always fully reduced to [0, P-1], including for non-canonical inputs up to 2^WIDTH-1.

Parameters:
- WIDTH, 255, field element width; P = 2^WIDTH - C.
- C, 19, pseudo-Mersenne constant; requires 1 <= C and C*C + 4*C < 2^WIDTH.
- DIGIT, 16, bits of b consumed per multiply cycle. 1 <= DIGIT <= WIDTH; need not divide WIDTH.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-low.
- start  input  1  request; sampled only when busy=0.
- op  input  2  00 MUL a*b, 01 SQR a*a (b ignored), 10 ADD a+b, 11 SUB a-b.
- a  input  WIDTH  operand, any value in [0, 2^WIDTH-1].
- b  input  WIDTH  operand, any value in [0, 2^WIDTH-1].
- busy  output  1  high while an operation is in flight.
- result  output  WIDTH  reduced result; held until the next valid.
- valid  output  1  one-cycle pulse when result updates.

Behaviour:
- Reset (rst=0, any time, including mid-operation): state=IDLE, busy=0, valid=0, result=0, all datapath registers 0. No stale valid after release.
- N = ceil(WIDTH/DIGIT). b is zero-extended to N*DIGIT bits.
- States: IDLE, MULT, FOLD1, FOLD2, CORR.
- IDLE:
  - start=1 captures a, b (b:=a for SQR) and op, then sets busy=1.
  - MUL/SQR: acc:=0, digit counter:=0, go to MULT.
  - ADD: t:=a+b, go to FOLD2.
  - SUB: t:=a + (2P - b), go to FOLD2. t is always non-negative.
- MULT: one cycle per digit, MSB digit first: acc := (acc << DIGIT) + a*digit. acc is 2*WIDTH bits wide. After N cycles, go to FOLD1.
- FOLD1: t := acc[WIDTH-1:0] + acc[2W-1:WIDTH]*C.
- FOLD2: t := t[WIDTH-1:0] + t[high]*C. Guarantees t < 2P.
- CORR: result := (t >= P) ? t-P : t; valid<=1; busy<=0; return to IDLE. Exactly one conditional subtract.
- Internal width of t: WIDTH + ceil(log2(C+1)) + 2 bits minimum; no truncation anywhere.
- Latency is counted in rising edges after the edge that samples start, up to the edge that sets valid:
  - MUL/SQR: N+3 (19 at defaults).
  - ADD/SUB: 2.
  - Latency is independent of operand values.
- Handshake:
  - busy rises on the edge that accepts start and falls on the edge that sets valid.
  - start while busy=1 is ignored, not queued; inputs may change freely while busy.
  - start high in the valid cycle is accepted (busy=0 then), allowing back-to-back issue with no bubble.
  - valid is high for exactly one cycle per accepted request.
- op and operands are latched only at acceptance.

Test Plan:
- Reset: hold rst=0 with start=1 and random inputs -> busy=0, valid=0, result=0. Assert rst=0 mid-MULT at cycle 5 and release -> no valid pulse; next request completes normally.
- Defaults, MUL: a=2, b=3 -> result=6, valid on edge 19 after start. a=b=P-1 -> result 1. a=2^254, b=2 -> result 19.
- Defaults, SQR with non-canonical input: a=2^255-1 (=P+18), b=0x5A -> result 324, b ignored. ADD a=P-1, b=2 -> 1 at latency 2. SUB a=0, b=1 -> P-1. SUB a=5, b=5 -> 0.
- Back-to-back: MUL issued, then start held high through the valid cycle with ADD a=1, b=1 -> second request accepted in the valid cycle, result 2 valid 2 edges later. A start pulsed during busy is dropped (exactly two valid pulses total).
- Small config WIDTH=8, C=5 (P=251), DIGIT=3 (N=3, latency 6): exhaustive MUL/SQR/ADD/SUB over a, b in [0,255] against a reference model computing (a op b) mod 251. Spot checks: 250*250 -> 1, 255+255 -> 8.
- Latency/timing: for each op, check busy high for exactly the required cycle count and valid is a single-cycle pulse. result must stay stable between pulses while inputs toggle randomly.
